// File: rtl/ula_pkg.sv
// Shared types and constants for the sequential ULA: opcodes, FSM states and flag bit positions.
package ula_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_NOTA = 3'b010,
        OP_NAND = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_LSL  = 3'b110,
        OP_LSR  = 3'b111
    } ula_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ula_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/ula_core_comb.sv
// Combinational logic/arithmetic unit: single-cycle ops plus flag generation.
// Shift opcodes pass A through, which is exactly the zero-count shift result.
module ula_core_comb
    import ula_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       s,
    output logic [WIDTH-1:0] r,
    output logic [3:0]       flags
);

    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] res,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = res[WIDTH-1];
        f[FLAG_Z] = (res == {WIDTH{1'b0}});
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] res_s;
    logic             c_s;
    logic             v_s;

    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} - {1'b0, b};

    // Opcode decode; SUB carry is the borrow, i.e. set iff A < B unsigned.
    always_comb begin
        res_s = {WIDTH{1'b0}};
        c_s   = 1'b0;
        v_s   = 1'b0;
        case (ula_op_t'(s))
            OP_AND:  res_s = a & b;
            OP_OR:   res_s = a | b;
            OP_NOTA: res_s = ~a;
            OP_NAND: res_s = ~(a & b);
            OP_ADD: begin
                res_s = sum_s[WIDTH-1:0];
                c_s   = sum_s[WIDTH];
                v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_s = diff_s[WIDTH-1:0];
                c_s   = diff_s[WIDTH];
                v_s   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_LSL:  res_s = a;
            OP_LSR:  res_s = a;
            default: res_s = {WIDTH{1'b0}};
        endcase
    end

    // Drive outputs from the decoded result.
    always_comb begin
        r     = res_s;
        flags = make_flags(res_s, c_s, v_s);
    end

endmodule

// File: rtl/ula_seq_param.sv
// Sequential WIDTH-bit ULA with valid/ready handshakes, bit-serial shifts
// and registered result and N/Z/C/V flags.
module ula_seq_param
    import ula_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       s,
    output logic [WIDTH-1:0] r,
    output logic [3:0]       flags,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    ula_state_t         state_r;
    ula_state_t         state_next_s;
    logic [WIDTH-1:0]   shreg_r;
    logic [SHAMT_W-1:0] cnt_r;
    logic               dir_right_r;
    logic [WIDTH-1:0]   r_r;
    logic [3:0]         flags_r;
    logic               out_valid_r;

    logic [WIDTH-1:0]   core_r_s;
    logic [3:0]         core_flags_s;
    logic               accept_s;
    logic               is_shift_s;
    logic               long_shift_s;
    logic               shift_done_s;
    logic [WIDTH-1:0]   sh_next_s;
    logic               sh_out_s;
    logic [3:0]         sh_flags_s;

    ula_core_comb #(.WIDTH(WIDTH)) u_core (
        .a     (a),
        .b     (b),
        .s     (s),
        .r     (core_r_s),
        .flags (core_flags_s)
    );

    assign accept_s     = in_valid && (state_r == IDLE);
    assign is_shift_s   = (ula_op_t'(s) == OP_LSL) || (ula_op_t'(s) == OP_LSR);
    assign long_shift_s = is_shift_s && (b[SHAMT_W-1:0] != {SHAMT_W{1'b0}});
    assign shift_done_s = (state_r == SHIFT) && (cnt_r == CNT_ONE);

    // One-bit shift step with zero fill; the bit leaving is the candidate carry.
    always_comb begin
        if (dir_right_r) begin
            sh_next_s = {1'b0, shreg_r[WIDTH-1:1]};
            sh_out_s  = shreg_r[0];
        end else begin
            sh_next_s = {shreg_r[WIDTH-2:0], 1'b0};
            sh_out_s  = shreg_r[WIDTH-1];
        end
        sh_flags_s         = 4'b0000;
        sh_flags_s[FLAG_N] = sh_next_s[WIDTH-1];
        sh_flags_s[FLAG_Z] = (sh_next_s == {WIDTH{1'b0}});
        sh_flags_s[FLAG_C] = sh_out_s;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = long_shift_s ? SHIFT : DONE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CNT_ONE) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath: shift register, count and the result/flag output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r     <= {WIDTH{1'b0}};
            cnt_r       <= {SHAMT_W{1'b0}};
            dir_right_r <= 1'b0;
            r_r         <= {WIDTH{1'b0}};
            flags_r     <= 4'b0000;
            out_valid_r <= 1'b0;
        end else begin
            if (accept_s && long_shift_s) begin
                shreg_r     <= a;
                cnt_r       <= b[SHAMT_W-1:0];
                dir_right_r <= (ula_op_t'(s) == OP_LSR);
            end else if (state_r == SHIFT) begin
                shreg_r <= sh_next_s;
                cnt_r   <= cnt_r - CNT_ONE;
            end
            if (accept_s && !long_shift_s) begin
                r_r     <= core_r_s;
                flags_r <= core_flags_s;
            end else if (shift_done_s) begin
                r_r     <= sh_next_s;
                flags_r <= sh_flags_s;
            end
            out_valid_r <= (state_next_s == DONE);
        end
    end

    // Output decode: in_ready comes from the state register only.
    always_comb begin
        in_ready  = (state_r == IDLE);
        r         = r_r;
        flags     = flags_r;
        out_valid = out_valid_r;
    end

endmodule
